// File: rtl/dht11_pkg.sv
// dht11_pkg: shared definitions for the DHT11 sensor emulator.
//   - dht11_state_e : bus/response state machine encoding
//   - DEF_*         : default phase lengths in clock cycles
//   - dht11_checksum: frame checksum (8-bit wrap-around sum)
package dht11_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_LO  = 3'd1,
    REQ_HI  = 3'd2,
    RESP_LO = 3'd3,
    RESP_HI = 3'd4,
    BIT_LO  = 3'd5,
    BIT_HI  = 3'd6,
    END_LO  = 3'd7
  } dht11_state_e;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_T_START_MIN = 4;
  localparam int DEF_T_WAIT      = 2;
  localparam int DEF_T_RESP_LO   = 8;
  localparam int DEF_T_RESP_HI   = 8;
  localparam int DEF_T_BIT_LO    = 5;
  localparam int DEF_T_ZERO_HI   = 3;
  localparam int DEF_T_ONE_HI    = 7;
  localparam int DEF_T_END_LO    = 5;

  // Sum is formed in 10 bits so the carry is explicit, then truncated.
  function automatic logic [7:0] dht11_checksum(input logic [7:0] a, input logic [7:0] b,
                                                input logic [7:0] c, input logic [7:0] d);
    logic [9:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return s[7:0];
  endfunction

endpackage

// File: rtl/dht11_sensor_model_if.sv
// dht11_sensor_model_if: observation bundle of the DHT11 emulator.
//   state     : current FSM state
//   bit_idx   : index of the frame bit being sent (39 down to 0)
//   drive_low : 1 while the emulator pulls the open-drain line low
//   busy      : 1 from RESP_LO through END_LO
// All fields are registered or decoded from registered state and are
// valid every cycle; there is no valid/ready handshake here -- the
// consumer (slave) samples whenever it likes, the producer (master)
// never waits.
interface dht11_sensor_model_if;
  dht11_pkg::dht11_state_e state;
  logic [5:0]              bit_idx;
  logic                    drive_low;
  logic                    busy;

  modport master (output state, output bit_idx, output drive_low, output busy);
  modport slave  (input  state, input  bit_idx, input  drive_low, input  busy);
endinterface

// File: rtl/dht11_sync.sv
// dht11_sync: two-flop synchronizer for the single-wire bus input.
//   clk, rst_n : clock, async active-low reset
//   i_d        : raw bus level
//   o_q        : synchronized level; resets to 1 (idle bus is pulled up)
module dht11_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/dht11_sensor_model.sv
// dht11_sensor_model: DHT11 humidity/temperature sensor emulator on an
// open-drain single-wire bus. Detects a host start request, answers with
// the response preamble and a 40-bit frame {HUM_INT, HUM_DEC, TMP_INT,
// TMP_DEC, CHK}, MSB first.
//   clk, rst_n : clock, async active-low reset
//   data_io    : open-drain bus (driven 0 or Z only; external pull-up)
//   busy       : high while a response is in progress
//   o_dbg      : state / bit index / drive observation bundle
module dht11_sensor_model
  import dht11_pkg::*;
#(
  parameter logic [7:0] HUM_INT     = 8'd45,
  parameter logic [7:0] HUM_DEC     = 8'd0,
  parameter logic [7:0] TMP_INT     = 8'd23,
  parameter logic [7:0] TMP_DEC     = 8'd0,
  parameter int         CNT_W       = DEF_CNT_W,
  parameter int         T_START_MIN = DEF_T_START_MIN,
  parameter int         T_WAIT      = DEF_T_WAIT,
  parameter int         T_RESP_LO   = DEF_T_RESP_LO,
  parameter int         T_RESP_HI   = DEF_T_RESP_HI,
  parameter int         T_BIT_LO    = DEF_T_BIT_LO,
  parameter int         T_ZERO_HI   = DEF_T_ZERO_HI,
  parameter int         T_ONE_HI    = DEF_T_ONE_HI,
  parameter int         T_END_LO    = DEF_T_END_LO
) (
  input  logic                        clk,
  input  logic                        rst_n,
  inout  wire                         data_io,
  output logic                        busy,
  dht11_sensor_model_if.master        o_dbg
);

  localparam logic [39:0] FRAME = {HUM_INT, HUM_DEC, TMP_INT, TMP_DEC,
                                   dht11_checksum(HUM_INT, HUM_DEC, TMP_INT, TMP_DEC)};

  // Phase counters run 0..T-1, so every phase compares against T-1.
  localparam logic [CNT_W-1:0] L_START   = CNT_W'(T_START_MIN - 1);
  localparam logic [CNT_W-1:0] L_WAIT    = CNT_W'(T_WAIT - 1);
  localparam logic [CNT_W-1:0] L_RESP_LO = CNT_W'(T_RESP_LO - 1);
  localparam logic [CNT_W-1:0] L_RESP_HI = CNT_W'(T_RESP_HI - 1);
  localparam logic [CNT_W-1:0] L_BIT_LO  = CNT_W'(T_BIT_LO - 1);
  localparam logic [CNT_W-1:0] L_ZERO_HI = CNT_W'(T_ZERO_HI - 1);
  localparam logic [CNT_W-1:0] L_ONE_HI  = CNT_W'(T_ONE_HI - 1);
  localparam logic [CNT_W-1:0] L_END_LO  = CNT_W'(T_END_LO - 1);

  dht11_state_e     r_state;
  dht11_state_e     w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [CNT_W-1:0] w_hi_last;
  logic [5:0]       r_idx;
  logic [5:0]       w_idx_nxt;
  logic [39:0]      r_frame;
  logic             r_own1;
  logic             r_own2;
  logic             w_din_raw;
  logic             w_din;
  logic             w_drive_low;

  dht11_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (data_io),
    .o_q   (w_din_raw)
  );

  // Our own low pulses come back through the synchronizer two cycles
  // late. Delaying the drive flag by the same two flops masks that echo,
  // so the tail of END_LO is not mistaken for a new host request in IDLE.
  assign w_din     = w_din_raw | r_own2;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_hi_last = r_frame[r_idx] ? L_ONE_HI : L_ZERO_HI;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_frame <= FRAME;
      r_own1  <= 1'b0;
      r_own2  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_own1  <= w_drive_low;
      r_own2  <= r_own1;
      if (r_state == IDLE) r_frame <= FRAME;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (!w_din) begin
          w_state_nxt = REQ_LO;
          w_cnt_nxt   = '0;
        end
      end
      REQ_LO: begin
        if (!w_din) begin
          // Saturate: an arbitrarily long host low is still a start.
          if (r_cnt != '1) w_cnt_nxt = w_cnt_inc;
        end else if (r_cnt >= L_START) begin
          // The cycle that sees the release is the first wait-high cycle.
          if (T_WAIT <= 1) begin
            w_state_nxt = RESP_LO;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = REQ_HI;
            w_cnt_nxt   = CNT_W'(1);
          end
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      end
      REQ_HI: begin
        if (!w_din) begin
          w_state_nxt = REQ_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt >= L_WAIT) begin
          w_state_nxt = RESP_LO;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RESP_LO: begin
        if (r_cnt == L_RESP_LO) begin
          w_state_nxt = RESP_HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      RESP_HI: begin
        if (r_cnt == L_RESP_HI) begin
          w_state_nxt = BIT_LO;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 6'd39;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      BIT_LO: begin
        if (r_cnt == L_BIT_LO) begin
          w_state_nxt = BIT_HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      BIT_HI: begin
        if (r_cnt == w_hi_last) begin
          w_cnt_nxt = '0;
          if (r_idx == 6'd0) begin
            w_state_nxt = END_LO;
          end else begin
            w_state_nxt = BIT_LO;
            w_idx_nxt   = r_idx - 6'd1;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      END_LO: begin
        if (r_cnt == L_END_LO) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Decoded from the state register only, so an async reset releases the
  // line and drops busy in the same instant.
  assign w_drive_low = (r_state == RESP_LO) || (r_state == BIT_LO) || (r_state == END_LO);
  assign busy        = (r_state == RESP_LO) || (r_state == RESP_HI) || (r_state == BIT_LO) ||
                       (r_state == BIT_HI)  || (r_state == END_LO);

  assign data_io = w_drive_low ? 1'b0 : 1'bz;

  assign o_dbg.state     = r_state;
  assign o_dbg.bit_idx   = r_idx;
  assign o_dbg.drive_low = w_drive_low;
  assign o_dbg.busy      = busy;

endmodule

// File: tb/tb_dht11_sensor_model.sv
module tb_dht11_sensor_model;
  import dht11_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bus / DUTs ----------------
  logic host_low = 1'b0;
  logic sel      = 1'b0;   // 0: DUT A (defaults), 1: DUT B (checksum wrap)
  logic mon_en   = 1'b1;

  wire bus_a;
  wire bus_b;
  pullup (bus_a);
  pullup (bus_b);
  assign bus_a = (host_low && !sel) ? 1'b0 : 1'bz;
  assign bus_b = (host_low &&  sel) ? 1'b0 : 1'bz;

  logic busy_a;
  logic busy_b;
  dht11_sensor_model_if dbg_a ();
  dht11_sensor_model_if dbg_b ();

  dht11_sensor_model u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_io (bus_a),
    .busy    (busy_a),
    .o_dbg   (dbg_a)
  );

  dht11_sensor_model #(.HUM_INT(8'd200), .TMP_INT(8'd100)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .data_io (bus_b),
    .busy    (busy_b),
    .o_dbg   (dbg_b)
  );

  wire line     = sel ? bus_b : bus_a;
  wire busy_sel = sel ? busy_b : busy_a;

  // ---------------- scoreboard ----------------
  localparam int TG_GAP = 1, TG_BUSY1 = 2, TG_RLO = 3, TG_RHI = 4, TG_BLO = 5,
                 TG_BHI = 6, TG_ELO = 7, TG_TOT = 8, TG_BUSY0 = 9, TG_BYTE = 10;

  logic [31:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int t_rel   = 0;

  function automatic string tag_name(input int t);
    case (t)
      TG_GAP:   return "release_to_low";
      TG_BUSY1: return "busy_at_start";
      TG_RLO:   return "resp_lo_len";
      TG_RHI:   return "resp_hi_len";
      TG_BLO:   return "bit_lo_len";
      TG_BHI:   return "bit_hi_len";
      TG_ELO:   return "end_lo_len";
      TG_TOT:   return "frame_total_len";
      TG_BUSY0: return "busy_after_end";
      TG_BYTE:  return "frame_byte";
      default:  return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input int tag, input int val);
    logic [7:0]  t8;
    logic [23:0] v24;
    t8  = tag[7:0];
    v24 = val[23:0];
    exp_q.push_back({t8, v24});
  endtask

  task automatic pop_check(input int tag, input int act);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s: got %0d with no expected entry", tag_name(tag), act);
    end else begin
      e = exp_q.pop_front();
      if (int'(e[31:24]) != tag) begin
        n_tests++;
        n_fail++;
        $display("FAIL order: got %s expected %s", tag_name(tag), tag_name(int'(e[31:24])));
      end else begin
        check(tag_name(tag), act, int'(e[23:0]));
      end
    end
  endtask

  // Expected response for one accepted request with the given frame bytes.
  // Defaults: gap 2+2, preamble 8/8, bit low 5, bit high 3/7, end low 5.
  task automatic expect_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [7:0] b4);
    logic [39:0] f;
    int tot;
    f = {b0, b1, b2, b3, b4};
    push(TG_GAP, 4);
    push(TG_BUSY1, 1);
    push(TG_RLO, 8);
    push(TG_RHI, 8);
    tot = 16;
    for (int i = 39; i >= 0; i--) begin
      push(TG_BLO, 5);
      push(TG_BHI, f[i] ? 7 : 3);
      tot += 5 + (f[i] ? 7 : 3);
    end
    push(TG_ELO, 5);
    tot += 5;
    push(TG_TOT, tot);
    push(TG_BUSY0, 0);
    push(TG_BYTE, int'(b0));
    push(TG_BYTE, int'(b1));
    push(TG_BYTE, int'(b2));
    push(TG_BYTE, int'(b3));
    push(TG_BYTE, int'(b4));
  endtask

  // ---------------- driver tasks ----------------
  task automatic host_pulse(input int n);
    @(posedge clk);
    #1 host_low = 1'b1;
    repeat (n) @(posedge clk);
    #1 host_low = 1'b0;
    t_rel = cyc;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL response_timeout: %0d expected items outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (20) @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  task automatic measure(input logic lvl, output int len);
    len = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (line != lvl) return;
      len++;
    end
    n_tests++;
    n_fail++;
    $display("FAIL run_timeout: level %0d held %0d cycles, required a transition", lvl, len);
  endtask

  initial begin
    logic [39:0] fobs;
    int len;
    int tot;
    fobs = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mon_en && !host_low && line == 1'b0) begin
        pop_check(TG_GAP, cyc - t_rel);
        pop_check(TG_BUSY1, int'(busy_sel));
        measure(1'b0, len); tot = len;  pop_check(TG_RLO, len);
        measure(1'b1, len); tot += len; pop_check(TG_RHI, len);
        for (int b = 0; b < 40; b++) begin
          measure(1'b0, len); tot += len; pop_check(TG_BLO, len);
          measure(1'b1, len); tot += len; pop_check(TG_BHI, len);
          fobs = {fobs[38:0], (len > 5)};
        end
        measure(1'b0, len); tot += len; pop_check(TG_ELO, len);
        pop_check(TG_TOT, tot);
        pop_check(TG_BUSY0, int'(busy_sel));
        for (int k = 0; k < 5; k++) pop_check(TG_BYTE, int'(fobs[39-8*k -: 8]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int lows;
    int busy_seen;
    int found;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_line_a", int'(bus_a), 1);
    check("reset_line_b", int'(bus_b), 1);
    check("reset_busy_a", int'(busy_a), 0);
    check("reset_busy_b", int'(busy_b), 0);
    check("reset_state_a", int'(dbg_a.state), int'(IDLE));
    check("reset_state_b", int'(dbg_b.state), int'(IDLE));
    check("reset_idx_b", int'(dbg_b.bit_idx), 0);
    check("reset_drive_b", int'(dbg_b.drive_low), 0);
    check("reset_dbg_busy_a", int'(dbg_a.busy), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Nominal: 45.0 %RH, 23.0 C -> 2D 00 17 00 44; total 381 cycles
    expect_frame(8'h2D, 8'h00, 8'h17, 8'h00, 8'h44);
    host_pulse(8);
    wait_idle();

    // Glitch: 2-cycle low is not a start request
    host_pulse(2);
    lows = 0;
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus_a == 1'b0) lows++;
      if (busy_a) busy_seen = 1;
    end
    check("glitch_low_cycles", lows, 0);
    check("glitch_busy", busy_seen, 0);
    check("glitch_state", int'(dbg_a.state), int'(IDLE));

    // Restart: 8 low, 1 high, 4 low, release -> one response after final release
    expect_frame(8'h2D, 8'h00, 8'h17, 8'h00, 8'h44);
    host_pulse(8);
    host_pulse(4);
    wait_idle();

    // Reset in the middle of bit 20's high phase
    mon_en = 1'b0;
    host_pulse(8);
    found = 0;
    for (int i = 0; i < 2000 && found == 0; i++) begin
      @(negedge clk);
      if (dbg_a.state == BIT_HI && dbg_a.bit_idx == 6'd20) found = 1;
    end
    check("reach_bit20_high", found, 1);
    #1 check("prereset_busy", int'(busy_a), 1);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_line", int'(bus_a), 1);
    check("midreset_busy", int'(busy_a), 0);
    check("midreset_drive", int'(dbg_a.drive_low), 0);
    check("midreset_state", int'(dbg_a.state), int'(IDLE));
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(posedge clk);
    expect_frame(8'h2D, 8'h00, 8'h17, 8'h00, 8'h44);
    host_pulse(8);
    wait_idle();

    // Checksum wrap: 200 + 0 + 100 + 0 = 300 -> 0x2C
    sel = 1'b1;
    repeat (3) @(posedge clk);
    expect_frame(8'hC8, 8'h00, 8'h64, 8'h00, 8'h2C);
    host_pulse(8);
    wait_idle();
    sel = 1'b0;

    check("leftover_expected", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
